// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT,
        S_READY,
        S_ERR
    } seq_state_e;

    // Width of the shared hold/timeout counter; one extra code so it can saturate.
    function automatic int cntWidth(input int hold, input int timeout);
        int m;
        m = (hold > timeout) ? hold : timeout;
        return $clog2(m + 1);
    endfunction

    // Width of a domain index, never narrower than one bit.
    function automatic int stageWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Sequencer-side control/status bundle: restart/done in, per-domain resets and status out.
interface reset_seq_if
    import reset_seq_pkg::*;
#(
    parameter int N = 3
);
    localparam int SW = stageWidth(N);

    logic          i_restart;
    logic [N-1:0]  i_done;
    logic [N-1:0]  o_rst;
    logic          o_ready;
    logic          o_err;
    logic [SW-1:0] o_err_stage;

    modport master (
        input  i_restart,
        input  i_done,
        output o_rst,
        output o_ready,
        output o_err,
        output o_err_stage
    );

    modport slave (
        output i_restart,
        output i_done,
        input  o_rst,
        input  o_ready,
        input  o_err,
        input  o_err_stage
    );
endinterface

// File: rtl/reset_seq_timer.sv
// Loadable saturating up-counter with a terminal-count compare; shared between
// the inter-release hold delay and the per-domain init timeout.
module reset_seq_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] count;

    // Count enabled cycles from zero, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count >= term);
endmodule

// File: rtl/reset_sequencer.sv
// Releases N reset domains one at a time in index order, waits for each to
// report init done, raises ready when all are up, and flags a stuck domain.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N       = 3,
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic     clk,
    input  logic     reset,
    reset_seq_if.master bus
);
    localparam int KW = stageWidth(N);
    localparam int CW = cntWidth(HOLD, TIMEOUT);
    localparam logic [KW-1:0] LAST    = KW'(N - 1);
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD - 1);
    localparam logic [CW-1:0] TO_TC   = CW'(TIMEOUT - 1);

    seq_state_e    state;
    logic [KW-1:0] k;
    logic [N-1:0]  rst_q;
    logic          ready_q;
    logic          err_q;
    logic [KW-1:0] stage_q;

    logic          done_sel;
    logic          all_done;
    logic [N-1:0]  rel_mask;
    logic [N-1:0]  err_mask;
    logic          tmr_clear;
    logic          tmr_en;
    logic          tmr_tc;
    logic [CW-1:0] tmr_term;

    // Select the active domain's done bit and build the thermometer masks from k.
    always_comb begin
        done_sel = 1'b0;
        rel_mask = '0;
        err_mask = '0;
        for (int j = 0; j < N; j++) begin
            if (KW'(j) == k) begin
                done_sel = bus.i_done[j];
            end
            rel_mask[j] = (KW'(j) > k);
            err_mask[j] = (KW'(j) >= k);
        end
        all_done = &bus.i_done;
    end

    // Drive the shared timer: hold delay in HOLD, init timeout while awaiting done.
    always_comb begin
        tmr_term  = (state == S_HOLD) ? HOLD_TC : TO_TC;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        if (bus.i_restart) begin
            tmr_clear = 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    if (tmr_tc) tmr_clear = 1'b1;
                    else        tmr_en    = 1'b1;
                end
                S_RELEASE, S_WAIT: begin
                    if (done_sel || tmr_tc) tmr_clear = 1'b1;
                    else                    tmr_en    = 1'b1;
                end
                default: tmr_clear = 1'b1;
            endcase
        end
    end

    reset_seq_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .en    (tmr_en),
        .term  (tmr_term),
        .tc    (tmr_tc)
    );

    // Sequencing FSM; RELEASE is the first done sample after a domain's reset falls.
    always_ff @(posedge clk) begin
        if (reset || bus.i_restart) begin
            state   <= S_HOLD;
            k       <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            stage_q <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (tmr_tc) begin
                        rst_q <= rel_mask;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE, S_WAIT: begin
                    if (done_sel) begin
                        if (k == LAST) begin
                            state <= S_READY;
                        end else begin
                            k     <= k + KW'(1);
                            state <= S_HOLD;
                        end
                    end else if (tmr_tc) begin
                        err_q   <= 1'b1;
                        stage_q <= k;
                        rst_q   <= err_mask;
                        state   <= S_ERR;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_READY: begin
                    if (!all_done) begin
                        state   <= S_HOLD;
                        k       <= '0;
                        rst_q   <= '1;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

    assign bus.o_rst       = rst_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_stage = stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-domain instance and a 1-domain instance
// sharing one clock, checked against a queue of expected output snapshots.
module tb_reset_sequencer;

    typedef struct {
        string      tag;
        bit         which;
        logic [6:0] exp;
    } sb_t;

    logic clk;
    logic rst3;
    logic rst1;
    int   total;
    int   bad;
    sb_t  sb[$];

    reset_seq_if #(.N(3)) if3 ();
    reset_seq_if #(.N(1)) if1 ();

    reset_sequencer #(.N(3), .HOLD(4), .TIMEOUT(16)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3.master)
    );

    reset_sequencer #(.N(1), .HOLD(1), .TIMEOUT(16)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.master)
    );

    // Free-running clock shared by both instances.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pk(input logic [2:0] r, input logic rd,
                                      input logic er, input logic [1:0] st);
        return {r, rd, er, st};
    endfunction

    function automatic logic [6:0] pk1(input logic r, input logic rd,
                                       input logic er, input logic st);
        return {2'b00, r, rd, er, 1'b0, st};
    endfunction

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input bit which, input logic [6:0] e);
        sb_t item;
        item.tag   = tag;
        item.which = which;
        item.exp   = e;
        sb.push_back(item);
    endtask

    task automatic checkOutput();
        sb_t        item;
        logic [6:0] obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL sb_empty: observed=none expected=entry");
        end else begin
            item = sb.pop_front();
            if (item.which)
                obs = {2'b00, if1.o_rst, if1.o_ready, if1.o_err, 1'b0, if1.o_err_stage};
            else
                obs = {if3.o_rst, if3.o_ready, if3.o_err, if3.o_err_stage};
            assert (obs === item.exp) else begin
                bad++;
                $error("[TB] FAIL %s: observed rst/rdy/err/stg=%b required=%b",
                       item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic stepCheck(input string tag, input bit which, input int n,
                             input logic [6:0] e);
        expectOut(tag, which, e);
        applyStimulus(n);
        checkOutput();
    endtask

    // Linear directed sequence covering release timing, timeouts, restarts and resets.
    initial begin
        total = 0;
        bad   = 0;
        rst3  = 1'b1;
        rst1  = 1'b1;
        if3.i_restart = 1'b0;
        if3.i_done    = 3'b000;
        if1.i_restart = 1'b0;
        if1.i_done    = 1'b1;

        applyStimulus(2);
        stepCheck("n1_reset", 1, 0, pk1(1'b1, 1'b0, 1'b0, 1'b0));
        rst1 = 1'b0;
        stepCheck("n1_e1_release", 1, 1, pk1(1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck("n1_e2_not_ready", 1, 1, pk1(1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck("n1_e3_ready", 1, 1, pk1(1'b0, 1'b1, 1'b0, 1'b0));

        applyStimulus(2);
        stepCheck("reset_values", 0, 0, pk(3'b111, 1'b0, 1'b0, 2'd0));
        rst3 = 1'b0;
        stepCheck("t1_e3_hold", 0, 3, pk(3'b111, 1'b0, 1'b0, 2'd0));
        stepCheck("t1_e4_rel0", 0, 1, pk(3'b110, 1'b0, 1'b0, 2'd0));
        applyStimulus(1);
        if3.i_done = 3'b001;
        stepCheck("t1_e9_hold1", 0, 4, pk(3'b110, 1'b0, 1'b0, 2'd0));
        stepCheck("t1_e10_rel1", 0, 1, pk(3'b100, 1'b0, 1'b0, 2'd0));
        applyStimulus(1);
        if3.i_done = 3'b011;
        stepCheck("t1_e15_hold2", 0, 4, pk(3'b100, 1'b0, 1'b0, 2'd0));
        stepCheck("t1_e16_rel2", 0, 1, pk(3'b000, 1'b0, 1'b0, 2'd0));
        applyStimulus(1);
        if3.i_done = 3'b111;
        stepCheck("t1_e18_not_ready", 0, 1, pk(3'b000, 1'b0, 1'b0, 2'd0));
        stepCheck("t1_e19_ready", 0, 1, pk(3'b000, 1'b1, 1'b0, 2'd0));

        if3.i_done = 3'b011;
        stepCheck("t3_loss_restart", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        if3.i_done = 3'b111;
        stepCheck("t3_rerun_rel0", 0, 4, pk(3'b110, 1'b0, 1'b0, 2'd0));
        stepCheck("t3_rerun_rel2", 0, 11, pk(3'b000, 1'b0, 1'b0, 2'd0));
        stepCheck("t3_rerun_ready", 0, 1, pk(3'b000, 1'b1, 1'b0, 2'd0));

        rst3 = 1'b1;
        if3.i_done = 3'b000;
        stepCheck("t2_reset", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        rst3 = 1'b0;
        stepCheck("t2_e4_rel0", 0, 4, pk(3'b110, 1'b0, 1'b0, 2'd0));
        applyStimulus(1);
        if3.i_done = 3'b001;
        stepCheck("t2_e10_rel1", 0, 5, pk(3'b100, 1'b0, 1'b0, 2'd0));
        stepCheck("t2_e25_no_err", 0, 15, pk(3'b100, 1'b0, 1'b0, 2'd0));
        stepCheck("t2_e26_timeout", 0, 1, pk(3'b110, 1'b0, 1'b1, 2'd1));
        if3.i_done = 3'b111;
        stepCheck("t2_err_sticky", 0, 5, pk(3'b110, 1'b0, 1'b1, 2'd1));

        if3.i_restart = 1'b1;
        stepCheck("t5a_restart", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        if3.i_restart = 1'b0;
        stepCheck("t5a_rel0", 0, 4, pk(3'b110, 1'b0, 1'b0, 2'd0));
        stepCheck("t5a_rel2", 0, 11, pk(3'b000, 1'b0, 1'b0, 2'd0));
        stepCheck("t5a_ready", 0, 1, pk(3'b000, 1'b1, 1'b0, 2'd0));

        rst3 = 1'b1;
        if3.i_done = 3'b000;
        stepCheck("t5b_reset", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        rst3 = 1'b0;
        stepCheck("t5b_e19_no_err", 0, 19, pk(3'b110, 1'b0, 1'b0, 2'd0));
        stepCheck("t5b_e20_timeout0", 0, 1, pk(3'b111, 1'b0, 1'b1, 2'd0));
        if3.i_done    = 3'b111;
        rst3          = 1'b1;
        if3.i_restart = 1'b1;
        stepCheck("t5b_reset_and_restart", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        rst3          = 1'b0;
        if3.i_restart = 1'b0;
        stepCheck("t5b_rel0", 0, 4, pk(3'b110, 1'b0, 1'b0, 2'd0));
        stepCheck("t5b_ready", 0, 12, pk(3'b000, 1'b1, 1'b0, 2'd0));

        rst3 = 1'b1;
        if3.i_done = 3'b001;
        stepCheck("t4_reset", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        rst3 = 1'b0;
        stepCheck("t4_e11_wait1", 0, 11, pk(3'b100, 1'b0, 1'b0, 2'd0));
        rst3 = 1'b1;
        stepCheck("t4_reset_in_wait", 0, 1, pk(3'b111, 1'b0, 1'b0, 2'd0));
        rst3 = 1'b0;
        stepCheck("t4_e3_hold", 0, 3, pk(3'b111, 1'b0, 1'b0, 2'd0));
        stepCheck("t4_e4_rel0", 0, 1, pk(3'b110, 1'b0, 1'b0, 2'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
